// File: rtl/fft_stage_sequencer_if.sv
// Handshake/bus bundle between the FFT stage sequencer and its surroundings:
// host start/done, coefficient-mapper start/dv, and butterfly address issue.
interface fft_stage_sequencer_if #(
    parameter int N = 16
);
    localparam int AW = $clog2(N);
    localparam int SW = $clog2(N / 2);

    // Host side
    logic          start;
    logic          busy;
    logic          done;
    // Coefficient mapper side
    logic          cm_start;
    logic [SW-1:0] cm_stage;
    logic          cm_dv;
    // Butterfly / RAM side
    logic          bf_valid;
    logic          bf_ready;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [SW-1:0] tw_idx;
    logic          bank_sel;

    // The sequencer drives the datapath, so it is the master.
    modport master (
        input  start, cm_dv, bf_ready,
        output cm_start, cm_stage, bf_valid, addr_a, addr_b, tw_idx,
               bank_sel, busy, done
    );

    // Host plus datapath environment.
    modport slave (
        output start, cm_dv, bf_ready,
        input  cm_start, cm_stage, bf_valid, addr_a, addr_b, tw_idx,
               bank_sel, busy, done
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT FFT stage sequencer. For each of log2(N) stages it kicks the
// coefficient mapper, waits for its dv, issues N/2 butterfly address pairs
// with twiddle indices under valid/ready, drains the butterfly pipeline and
// flips the ping-pong bank. Reports busy/done to the host.
module fft_stage_sequencer #(
    parameter int N    = 16,
    parameter int PIPE = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    fft_stage_sequencer_if.master bus
);
    localparam int LOGN = $clog2(N);
    localparam int AW   = LOGN;
    localparam int SW   = $clog2(N / 2);
    localparam int DW   = (PIPE > 1) ? $clog2(PIPE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_COEF,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] s_q, s_d;        // current stage
    logic [SW-1:0] k_q, k_d;        // butterfly index within stage
    logic [DW-1:0] dcnt_q, dcnt_d;  // drain cycle counter
    logic          bank_q, bank_d;  // read bank

    logic          run;
    logic          transfer;
    logic          last_k;
    logic          last_s;
    logic          last_drain;

    logic [AW-1:0] k_ext;
    logic [AW-1:0] h;
    logic [AW-1:0] sh_hi;
    logic [AW-1:0] a_raw;
    logic [SW-1:0] tmask;
    logic [SW-1:0] twsh;
    logic [SW-1:0] tw_raw;

    assign run        = (state_q == S_RUN);
    assign transfer   = run & bus.bf_ready;
    assign last_k     = (k_q == SW'(N / 2 - 1));
    assign last_s     = (s_q == SW'(LOGN - 1));
    assign last_drain = (dcnt_q == DW'(PIPE - 1));

    // State and counter registers; all are control, so all are reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            k_q     <= '0;
            dcnt_q  <= '0;
            bank_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            dcnt_q  <= dcnt_d;
            bank_q  <= bank_d;
        end
    end

    // Next-state logic: stage loop LOAD -> WAIT_COEF -> RUN -> DRAIN, then DONE.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        dcnt_d  = dcnt_q;
        bank_d  = bank_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    s_d     = '0;
                    bank_d  = 1'b0;
                end
            end
            S_LOAD: begin
                // A dv arriving together with our own start pulse is stale.
                state_d = S_WAIT_COEF;
            end
            S_WAIT_COEF: begin
                if (bus.cm_dv) begin
                    state_d = S_RUN;
                    k_d     = '0;
                end
            end
            S_RUN: begin
                if (transfer) begin
                    if (last_k) begin
                        state_d = S_DRAIN;
                        dcnt_d  = '0;
                    end else begin
                        k_d = k_q + SW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (last_drain) begin
                    bank_d = ~bank_q;
                    if (last_s) begin
                        state_d = S_DONE;
                    end else begin
                        s_d     = s_q + SW'(1);
                        state_d = S_LOAD;
                    end
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            S_DONE: begin
                // Start seen here is dropped; it is sampled again in IDLE.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Butterfly address and twiddle generation from registered stage and index.
    always_comb begin
        k_ext  = AW'(k_q);
        h      = AW'(1) << s_q;
        sh_hi  = AW'(s_q) + AW'(1);
        a_raw  = ((k_ext >> s_q) << sh_hi) | (k_ext & (h - AW'(1)));
        // At the last stage the shift overflows to zero, giving an all-ones mask.
        tmask  = (SW'(1) << s_q) - SW'(1);
        twsh   = SW'(LOGN - 1) - s_q;
        tw_raw = (k_q & tmask) << twsh;
    end

    // Address outputs are forced to zero outside RUN so idle outputs read as 0.
    assign bus.bf_valid = run;
    assign bus.addr_a   = run ? a_raw : '0;
    assign bus.addr_b   = run ? (a_raw + h) : '0;
    assign bus.tw_idx   = run ? tw_raw : '0;
    assign bus.cm_start = (state_q == S_LOAD);
    assign bus.cm_stage = s_q;
    assign bus.bank_sel = bank_q;
    assign bus.busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done     = (state_q == S_DONE);
endmodule
